// File: rtl/rotor_table_loader.sv
// Streams one rotor's 26 forward-wiring letters into the shared rotor RAM and writes each forward and backward entry.
// Defining ROTOR_PERM_CHECK_EN rejects repeated letters, so that a completed load always holds a valid inverse.
module rotor_table_loader #(
  parameter int NUM_ROTORS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rotor_type,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_letter,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, LOAD, INV, DONE} state_t;

  localparam logic [15:0] NUM_ROTORS_W = 16'(NUM_ROTORS);

  state_t      state_q, state_d;
  logic [8:0]  base_q;
  logic [4:0]  idx_q;
  logic [4:0]  letter_q;
  logic        error_q;
  logic        type_ok;
  logic        letter_in_range;
  logic        letter_dup;
  logic        letter_ok;

  assign type_ok         = (rotor_type < NUM_ROTORS_W);
  assign letter_in_range = (in_letter <= 16'd25);

`ifdef ROTOR_PERM_CHECK_EN
  logic [25:0] seen_q;
  assign letter_dup = letter_in_range && seen_q[in_letter[4:0]];
`else
  assign letter_dup = 1'b0;
`endif

  assign letter_ok = letter_in_range && !letter_dup;

  // The addresses use 9-bit arithmetic. This gives the same result as summing in 16 bits and then truncating.
  always_comb begin
    // NOTE: every output gets a default first, so that no path can infer a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    unique case (state_q)
      IDLE: if (start && type_ok) state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (letter_ok) begin
            wr_en   = 1'b1;
            wr_addr = base_q + 9'(idx_q);
            wr_data = in_letter;
            state_d = INV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      INV: begin
        wr_en   = 1'b1;
        wr_addr = base_q + 9'd26 + 9'(letter_q);
        wr_data = 16'(idx_q);
        state_d = (idx_q == 5'd25) ? DONE : LOAD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: all sequential state is written with non-blocking assignments, so that every register sees pre-edge values.
      state_q  <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      letter_q <= '0;
      error_q  <= 1'b0;
`ifdef ROTOR_PERM_CHECK_EN
      seen_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          if (type_ok) begin
            base_q  <= 9'(rotor_type * 16'd52);
            idx_q   <= '0;
            error_q <= 1'b0;
`ifdef ROTOR_PERM_CHECK_EN
            seen_q  <= '0;
`endif
          end else begin
            error_q <= 1'b1;
          end
        end
        LOAD: if (in_valid) begin
          if (letter_ok) begin
            letter_q <= in_letter[4:0];
`ifdef ROTOR_PERM_CHECK_EN
            seen_q[in_letter[4:0]] <= 1'b1;
`endif
          end else begin
            error_q <= 1'b1;
          end
        end
        INV: if (idx_q != 5'd25) idx_q <= idx_q + 5'd1;
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == LOAD) || (state_q == INV);
  assign done  = (state_q == DONE);
  assign error = error_q;

endmodule

// File: tb/tb_rotor_table_loader.sv
// Scoreboard bench for rotor_table_loader. The bench queues the expected RAM writes per letter and pops them as the DUT writes.
// A small RAM model captures the writes, so that the bench can check the inverse table.
module tb_rotor_table_loader;

  localparam int NR = 8;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;
  typedef logic [15:0] wiring_t [26];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] rotor_type = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_letter = '0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  rotor_table_loader #(.NUM_ROTORS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .rotor_type(rotor_type),
    .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  int n_wr = 0;
  int n_done = 0;
  int load_start = 0;
  wr_t exp_q[$];
  logic [15:0] ram [512];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // The monitor samples on the falling edge. At that point the combinational write outputs have settled.
  initial begin : monitor
    bit prev_hs = 1'b0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", wr_en, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        ram[wr_addr] = wr_data;
        n_wr++;
      end else begin
        check("idle_wr_zero", {wr_addr, wr_data}, 0);
      end
      if (prev_hs) check("inv_ready_low", in_ready, 0);
      prev_hs = in_valid && in_ready;
      if (done) n_done++;
    end
  end

  task automatic start_load(input logic [15:0] t);
    @(posedge clk); #1;
    start = 1'b1;
    rotor_type = t;
    @(posedge clk); #1;
    start = 1'b0;
    load_start = cyc;
  endtask

  task automatic load_rotor(input logic [15:0] t, input wiring_t w, input int n, input bit gaps,
                            output int bad_at);
    logic [25:0] seen = '0;
    int base = int'(t) * 52;
    bit bad, hs;
    bad_at = -1;
    start_load(t);
    for (int k = 0; k < n; k++) begin
      bad = (w[k] > 16'd25);
`ifdef ROTOR_PERM_CHECK_EN
      if (!bad && seen[w[k][4:0]]) bad = 1'b1;
`endif
      if (!bad) begin
        exp_q.push_back('{addr: 9'(base + k), data: w[k]});
        exp_q.push_back('{addr: 9'(base + 26 + int'(w[k])), data: 16'(k)});
        seen[w[k][4:0]] = 1'b1;
      end
      in_letter = w[k];
      hs = 1'b0;
      for (int c = 0; c < 64 && !hs; c++) begin
        in_valid = (gaps && c < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        hs = in_valid && in_ready;
        if (!hs) begin
          @(posedge clk); #1;
        end
      end
      if (!hs) begin
        check("handshake_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bad) begin
        in_valid = 1'b0;
        bad_at = k;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input bit timed);
    bit got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    check("done_pulse", done, 1);
    if (timed) check("done_cycle", cyc - load_start, 52);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("no_error", error, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_tables(input int base, input wiring_t w);
    logic [15:0] f;
    for (int i = 0; i < 26; i++) begin
      f = ram[base + i];
      check("fwd_word", f, w[i]);
      check("bwd_of_fwd", ram[base + 26 + int'(f[4:0])], 16'(i));
    end
  endtask

  initial begin : stimulus
    wiring_t ident, rotor1, badw, dupw;
    string s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    int bad_at, w0, d0;
    for (int k = 0; k < 26; k++) begin
      ident[k]  = 16'(k);
      rotor1[k] = 16'(s[k] - 8'd65);
      badw[k]   = (k == 5) ? 16'd26 : 16'(k);
      dupw[k]   = 16'(k);
    end
    dupw[0] = 16'd3; dupw[1] = 16'd7; dupw[2] = 16'd3;
    for (int a = 0; a < 512; a++) ram[a] = 16'hDEAD;

    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    w0 = n_wr;
    load_rotor(16'd0, ident, 26, 1'b0, bad_at);
    finish_load(1'b1);
    check("ident_writes", n_wr - w0, 52);
    check_tables(0, ident);

    load_rotor(16'd2, rotor1, 26, 1'b0, bad_at);
    finish_load(1'b1);
    check("rotor1_first_fwd", ram[104], 16'd4);
    check("rotor1_first_bwd", ram[134], 16'd0);
    check_tables(104, rotor1);

    for (int a = 104; a < 156; a++) ram[a] = 16'hDEAD;
    load_rotor(16'd2, rotor1, 26, 1'b1, bad_at);
    finish_load(1'b0);
    check_tables(104, rotor1);

    w0 = n_wr; d0 = n_done;
    load_rotor(16'd0, badw, 26, 1'b0, bad_at);
    check("bad_letter_index", bad_at, 5);
    check("bad_letter_error", error, 1);
    check("bad_letter_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_letter_writes", n_wr - w0, 10);
    check("bad_letter_no_done", n_done - d0, 0);
    check("bad_letter_queue", exp_q.size(), 0);

    w0 = n_wr;
    start_load(16'(NR));
    check("bad_type_error", error, 1);
    check("bad_type_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bad_type_writes", n_wr - w0, 0);

    w0 = n_wr; d0 = n_done;
    start_load(16'd3);
    check("error_cleared", error, 0);
    check("busy_after_start", busy, 1);
    reset = 1'b1; #1; reset = 1'b0;
    load_rotor(16'd3, dupw, 26, 1'b0, bad_at);
`ifdef ROTOR_PERM_CHECK_EN
    check("dup_index", bad_at, 2);
    check("dup_error", error, 1);
    repeat (3) @(posedge clk);
    #1;
    check("dup_writes", n_wr - w0, 4);
    check("dup_no_done", n_done - d0, 0);
`else
    check("dup_no_abort", bad_at, -1);
    finish_load(1'b1);
    check("dup_writes", n_wr - w0, 52);
`endif

    load_rotor(16'd0, ident, 13, 1'b0, bad_at);
    check("mid_inv_busy", busy, 1);
    check("mid_inv_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_fwd_kept", ram[12], 16'd12);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 52; a < 104; a++) ram[a] = 16'hDEAD;
    load_rotor(16'd1, rotor1, 26, 1'b0, bad_at);
    finish_load(1'b1);
    check_tables(52, rotor1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation still running at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotor_table_loader.md
# rotor_table_loader

Write-side companion to the rotor datapath: accepts one rotor's forward wiring as a stream of 26 letter codes and writes both the forward table and the computed inverse (backward) table into the shared rotor RAM. Layout matches the read side exactly: rotor `type` occupies 52 words at base `52*type`. Forward entry `i` goes to `base+i`; backward entry `L` goes to `base+26+L`, holding `i`. It sits between the configuration/host interface and the rotor RAM's single write port.

## Interface
- `NUM_ROTORS`, default 8: number of rotor types held in RAM. Must be at most 9 so that `52*NUM_ROTORS <= 512` fits the 9-bit address space.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to load one rotor. Sampled only in IDLE.
- `type` in 16: rotor type to load. Sampled with `start`.
- `in_valid` in 1: `in_letter` holds a valid letter.
- `in_ready` out 1: loader can accept a letter this cycle.
- `in_letter` in 16: forward wiring output for the current index, range 0..25.
- `wr_en` out 1: RAM write strobe.
- `wr_addr` out 9: RAM write address.
- `wr_data` out 16: RAM write data.
- `busy` out 1: a load is in progress (states LOAD or INV).
- `done` out 1: one-cycle pulse when all 52 words of a rotor have been written.
- `error` out 1: sticky error flag. Cleared by the next accepted `start`.

## Operation
- States are IDLE, LOAD, INV and DONE.
- **IDLE**
  - `start` with `type < NUM_ROTORS`: latch `base = 52*type`, clear index `i` and `error`, go to LOAD.
  - `start` with `type >= NUM_ROTORS`: set `error`, stay in IDLE, no writes.
- **LOAD**
  - `in_ready = 1`.
  - On handshake (`in_valid && in_ready`) with `L <= 25`: `wr_en = 1`, `wr_addr = base+i`, `wr_data = L`. Latch `L`, go to INV.
  - On handshake with `L > 25`: no write, set `error`, go to IDLE.
- **INV**
  - `in_ready = 0`.
  - `wr_en = 1`, `wr_addr = base+26+L_latched`, `wr_data = i`.
  - If `i == 25`: go to DONE. Otherwise increment `i` and go to LOAD.
- **DONE**
  - `done = 1` for one cycle, then go to IDLE.
- Write outputs are combinational from state and handshake. `wr_addr` and `wr_data` are 0 whenever `wr_en = 0`.
- Address arithmetic is computed in 16 bits and truncated to 9 bits. This truncation is lossless under the `NUM_ROTORS` limit.
- `start` while `busy` is ignored.
- `in_valid` outside LOAD is ignored; no letter is consumed.
- An aborted load (error or reset) leaves the partially written table in RAM. No rollback.

## Timing
- Reset values: state IDLE, `i = 0`, `in_ready = 0`, `wr_en = 0`, `wr_addr = 0`, `wr_data = 0`, `busy = 0`, `done = 0`, `error = 0`.
- Reset mid-load aborts immediately; writes already issued remain in RAM.
- `start` in cycle t puts the block in LOAD at t+1.
- Each letter costs 2 cycles: forward write in the handshake cycle, backward write in the next cycle.
- With `in_valid` held high, the load takes 52 cycles from the first LOAD cycle, and `done` is asserted in cycle 53.
- Upstream gaps on `in_valid` only stretch time spent in LOAD. Write order is unchanged.
- `error` asserts on the cycle after the offending handshake or `start`. It holds until the next accepted `start`.

## Configuration
- `ROTOR_PERM_CHECK_EN` defined:
  - Keep a 26-bit seen-mask, cleared on accepted `start`.
  - A handshake whose letter has already been seen is treated like an out-of-range letter: no write, `error` set, return to IDLE.
  - This guarantees that a completed load produces a valid inverse table.
- `ROTOR_PERM_CHECK_EN` not defined:
  - No mask is kept.
  - Duplicate letters are written normally; the later backward write overwrites the earlier one.
  - `done` still pulses.

## Test plan
- **Identity rotor.** `type = 0`, letters 0..25 with `in_valid` held high → writes (0,0), (26,0), (1,1), (27,1), … (25,25), (51,25); `done` pulses at cycle 53; `error = 0`.
- **Rotor I wiring.** "EKMFLGDQVZNTOWYHXUSPAIBRCJ" on `type = 2` → first writes (104,4) then (134,0); final RAM words 104..155 read back so that `bwd[fwd[i]] == i` for all i.
- **Backpressure.** Same load with `in_valid` toggling on random cycles → identical write sequence; `in_ready` low in every INV cycle.
- **Bad inputs.**
  - Letter 26 at index 5 → 10 writes issued, then `error = 1`, `busy = 0`, no `done`.
  - `start` with `type = NUM_ROTORS` → `error = 1`, no writes.
- **Duplicate letter, macro defined.** `ROTOR_PERM_CHECK_EN` defined, letters 3, 7, 3 → 4 writes issued, `error = 1` after the third handshake; with the macro undefined the same stimulus continues and the load completes.
- **Reset mid-load.** Assert `reset` during INV at index 12 → all outputs 0 immediately; a subsequent full load of `type = 1` completes normally.
